// File: rtl/sram1rw_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous SRAM among N_REQ requesters.
// Define SRAM1RW_ARB_INIT_EN to zero-fill the array after reset before any grant is issued.

module sram1rw #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  we,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (ce && we) mem[addr] <= wdata;
    end

    // Read-before-write: the output captures the old word; init sweep leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rdata <= '0;
        else if (ce && rd_en) rdata <= mem[addr];
    end
endmodule

module sram1rw_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        init_done
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0]  ST_RUN = 1'b1;
`ifdef SRAM1RW_ARB_INIT_EN
    localparam logic [0:0]  ST_INIT = 1'b0;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH   = 2**ADDR_WIDTH;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             done_d;
`endif

    logic [0:0]            state, state_d;
    logic [PTR_W-1:0]      rr_ptr, ptr_d, gidx;
    logic [N_REQ-1:0]      grant;
    logic                  found;
    int                    s;
    logic                  sram_ce, sram_we, sram_rd;
    logic [ADDR_WIDTH-1:0] sram_addr, addr_hold;
    logic [DATA_WIDTH-1:0] sram_wdata;

    // Next-state, grant search and SRAM port mux.
    always_comb begin
        state_d    = state;
        ptr_d      = rr_ptr;
        grant      = '0;
        gidx       = '0;
        found      = 1'b0;
        s          = 0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_rd    = 1'b0;
        sram_addr  = addr_hold;
        sram_wdata = '0;
`ifdef SRAM1RW_ARB_INIT_EN
        cnt_d  = cnt;
        done_d = init_done;
        if (state == ST_INIT) begin
            if (cnt == CNT_W'(DEPTH)) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end else begin
                sram_ce   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = cnt[ADDR_WIDTH-1:0];
                cnt_d     = cnt + 1'b1;
            end
        end
`endif
        if (state == ST_RUN && rst_n) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                s = int'(rr_ptr) + k;
                if (s >= int'(N_REQ)) s = s - int'(N_REQ);
                if (!found && req_valid[PTR_W'(s)]) begin
                    found               = 1'b1;
                    gidx                = PTR_W'(s);
                    grant[PTR_W'(s)]    = 1'b1;
                end
            end
        end
        if (found) begin
            sram_ce    = 1'b1;
            sram_rd    = 1'b1;
            sram_we    = req_we[gidx];
            sram_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
            ptr_d      = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SRAM1RW_ARB_INIT_EN
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
`else
            state     <= ST_RUN;
`endif
            rr_ptr    <= '0;
            rsp_valid <= '0;
            addr_hold <= '0;
        end else begin
`ifdef SRAM1RW_ARB_INIT_EN
            cnt       <= cnt_d;
            init_done <= done_d;
`endif
            state     <= state_d;
            rr_ptr    <= ptr_d;
            rsp_valid <= grant;
            if (sram_ce) addr_hold <= sram_addr;
        end
    end

`ifndef SRAM1RW_ARB_INIT_EN
    assign init_done = 1'b1;
`endif

    sram1rw #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (sram_ce),
        .we    (sram_we),
        .rd_en (sram_rd),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (rsp_rdata)
    );
endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Directed bench for sram1rw_arbiter (N_REQ=3, ADDR_WIDTH=4, DATA_WIDTH=32).
// Follows SRAM1RW_ARB_INIT_EN the same way the RTL does.

module tb_sram1rw_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata;
    logic            init_done;
    int              errs   = 0;
    int              checks = 0;

    sram1rw_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] e;
        clr_req();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rdata", 64'(rsp_rdata), 64'h0);
`ifdef SRAM1RW_ARB_INIT_EN
        check("rst_init_done", 64'(init_done), 64'h0);
`else
        check("rst_init_done", 64'(init_done), 64'h1);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

`ifdef SRAM1RW_ARB_INIT_EN
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n == 1 || n == 16) check("init_busy", 64'(init_done), 64'h0);
            if (n == 16) check("init_no_grant", 64'(req_ready), 64'h0);
            if (n == 17) check("init_done", 64'(init_done), 64'h1);
        end
`else
        // Fill with zeros so later reads are deterministic; first grant lands before the 1st edge.
        for (int a = 0; a < 16; a++) begin
            set_req(0, 1'b1, AW'(a), '0);
            #1;
            if (a == 0) check("first_edge_ready", 64'(req_ready), 64'h1);
            tick();
        end
        clr_req();
        set_req(2, 1'b0, 4'h0, '0);
        tick();
        clr_req();
`endif

        // Read after init/fill returns zero; pointer starts at 0.
        set_req(0, 1'b0, 4'h5, '0);
        #1 check("t1_ready", 64'(req_ready), 64'h1);
        tick();
        clr_req();
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rdata", 64'(rsp_rdata), 64'h0);

        // Write then read-back on consecutive cycles.
        set_req(0, 1'b1, 4'h3, 32'hDEADBEEF);
        #1 check("t2_wr_ready", 64'(req_ready), 64'h1);
        tick();
        check("t2_wr_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t2_wr_old_data", 64'(rsp_rdata), 64'h0);
        set_req(0, 1'b0, 4'h3, '0);
        #1 check("t2_rd_ready", 64'(req_ready), 64'h1);
        tick();
        clr_req();
        check("t2_rd_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t2_rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
        tick();
        check("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        check("idle_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);

        // Bring pointer back to 0, then all three requesters contend for 6 cycles.
        set_req(2, 1'b0, 4'h5, '0);
        tick();
        clr_req();
        set_req(0, 1'b0, 4'h3, '0);
        set_req(1, 1'b0, 4'h5, '0);
        set_req(2, 1'b0, 4'h3, '0);
        for (int c = 0; c < 6; c++) begin
            e = 3'b001 << (c % 3);
            #1 check("t3_ready", 64'(req_ready), 64'(e));
            tick();
            check("t3_rsp_valid", 64'(rsp_valid), 64'(e));
            check("t3_rdata", 64'(rsp_rdata), (c % 3 == 1) ? 64'h0 : 64'hDEADBEEF);
        end
        clr_req();

        // Pointer at 2 with requesters 0/1 pending, then wrap.
        set_req(1, 1'b0, 4'h5, '0);
        tick();
        clr_req();
        set_req(0, 1'b0, 4'h3, '0);
        set_req(1, 1'b0, 4'h5, '0);
        #1 check("t4_wrap_ready", 64'(req_ready), 64'h1);
        tick();
        check("t4_wrap_rsp", 64'(rsp_valid), 64'h1);
        clr_req();
        set_req(1, 1'b0, 4'h5, '0);
        set_req(2, 1'b0, 4'h3, '0);
        #1 check("t4_next_ready", 64'(req_ready), 64'h2);
        tick();
        check("t4_next_rsp", 64'(rsp_valid), 64'h2);
        check("t4_next_rdata", 64'(rsp_rdata), 64'h0);
        clr_req();

        // Write by requester 1 seen by read from requester 2 on the next cycle.
        set_req(1, 1'b1, 4'h7, 32'h000000A5);
        #1 check("t5_wr_ready", 64'(req_ready), 64'h2);
        tick();
        check("t5_wr_rsp", 64'(rsp_valid), 64'h2);
        clr_req();
        set_req(2, 1'b0, 4'h7, '0);
        #1 check("t5_rd_ready", 64'(req_ready), 64'h4);
        tick();
        clr_req();
        check("t5_rd_rsp", 64'(rsp_valid), 64'h4);
        check("t5_rd_data", 64'(rsp_rdata), 64'hA5);

        // Reset with a response showing and another read pending.
        set_req(0, 1'b0, 4'h3, '0);
        tick();
        check("t6_pre_rsp", 64'(rsp_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rsp", 64'(rsp_valid), 64'h0);
        check("t6_rst_ready", 64'(req_ready), 64'h0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("t6_rel_rsp", 64'(rsp_valid), 64'h0);
`ifdef SRAM1RW_ARB_INIT_EN
        check("t6_init_ready", 64'(req_ready), 64'h0);
        for (int n = 0; n < 40 && !init_done; n++) tick();
        check("t6_init_done", 64'(init_done), 64'h1);
        check("t6_run_ready", 64'(req_ready), 64'h1);
        tick();
        check("t6_rsp", 64'(rsp_valid), 64'h1);
        check("t6_swept_data", 64'(rsp_rdata), 64'h0);
`else
        check("t6_run_ready", 64'(req_ready), 64'h1);
        tick();
        check("t6_rsp", 64'(rsp_valid), 64'h1);
        check("t6_kept_data", 64'(rsp_rdata), 64'hDEADBEEF);
`endif
        clr_req();
        tick();
        check("t6_idle_rsp", 64'(rsp_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
